tx_pulse_ch: RTL and testbench

- Per-channel transmit beamforming element, the transmit-side counterpart of the receive DBF channel.
- Holds a per-focal-zone transmit delay LUT and, on a frame trigger, waits the selected delay.
- Then emits a bipolar pulse train (pulse_p/pulse_n) to the channel's pulser.
- One instance per element; all instances share trigger, zone select and waveform settings.

---
 rtl/tx_pulse_ch_if.sv | 46 ++++
 rtl/tx_pulse_ch.sv | 220 ++++++++++++++++++++++
 tb/tb_tx_pulse_ch.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/tx_pulse_ch_if.sv
// -----------------------------------------------------------------------------
// tx_pulse_ch_if
// Bundle of the control, LUT-programming and pulser-drive signals of one
// transmit beamforming channel.
//   master : controller side (drives LUT writes, trigger, settings; sees outputs)
//   slave  : channel side (tx_pulse_ch)
// Signals:
//   lut_we/lut_addr/lut_din   delay LUT write port
//   zone_sel                  focal zone used by the next transmit
//   half_period/num_cycles    waveform settings
//   tx_trig/tx_abort          transmit start / synchronous abort
//   pulse_p/pulse_n           bipolar pulser drive
//   tx_en/tx_busy/tx_done     train-active, not-idle, completion strobe
// -----------------------------------------------------------------------------
interface tx_pulse_ch_if #(
    parameter int DLY_WD  = 12,
    parameter int ADDR_WD = 7,
    parameter int HALF_WD = 4,
    parameter int CYC_WD  = 4
);
    logic               lut_we;
    logic [ADDR_WD-1:0] lut_addr;
    logic [DLY_WD-1:0]  lut_din;
    logic [ADDR_WD-1:0] zone_sel;
    logic [HALF_WD-1:0] half_period;
    logic [CYC_WD-1:0]  num_cycles;
    logic               tx_trig;
    logic               tx_abort;
    logic               pulse_p;
    logic               pulse_n;
    logic               tx_en;
    logic               tx_busy;
    logic               tx_done;

    modport master (
        output lut_we, lut_addr, lut_din, zone_sel, half_period, num_cycles,
               tx_trig, tx_abort,
        input  pulse_p, pulse_n, tx_en, tx_busy, tx_done
    );

    modport slave (
        input  lut_we, lut_addr, lut_din, zone_sel, half_period, num_cycles,
               tx_trig, tx_abort,
        output pulse_p, pulse_n, tx_en, tx_busy, tx_done
    );
endinterface

// File: rtl/tx_pulse_ch.sv
// -----------------------------------------------------------------------------
// tx_pulse_ch
// Per-element transmit beamforming channel. Holds a per-focal-zone delay LUT;
// on a trigger it latches the zone and waveform settings, reads the zone's
// delay, counts it down and then drives a bipolar P/N pulse train.
// Ports:
//   clk    system clock (40 MHz)
//   rst_n  asynchronous reset, ACTIVE HIGH despite its name
//   bus    tx_pulse_ch_if.slave (LUT write, trigger/abort, settings, outputs)
// Optional feature:
//   TX_DEAD_TIME_EN  when defined, one dead cycle (pulse_p=pulse_n=0, tx_en=1)
//                    separates every P->N and N->P change inside a train.
// Timing (edge 0 = edge that samples tx_trig, D = LUT delay, L = train length):
//   pulse_p/tx_en rise at edge 3+D, tx_done at edge 4+D+L, tx_busy is high
//   from edge 1 through the tx_done cycle.
// -----------------------------------------------------------------------------
module tx_pulse_ch #(
    parameter int DLY_WD  = 12,
    parameter int ADDR_WD = 7,
    parameter int HALF_WD = 4,
    parameter int CYC_WD  = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    tx_pulse_ch_if.slave  bus
);

`ifdef TX_DEAD_TIME_EN
    localparam logic DEAD_EN = 1'b1;
`else
    localparam logic DEAD_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_DELAY   = 3'd2,
        S_PULSE_P = 3'd3,
        S_PULSE_N = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    // Delay LUT, deliberately without reset
    logic [DLY_WD-1:0]  r_lut [2**ADDR_WD];

    state_t             r_state,   w_state_nxt;
    logic [ADDR_WD-1:0] r_zone,    w_zone_nxt;
    logic [HALF_WD-1:0] r_half,    w_half_nxt;
    logic [CYC_WD-1:0]  r_cyc,     w_cyc_nxt;
    logic [DLY_WD-1:0]  r_dly,     w_dly_nxt;
    logic [HALF_WD-1:0] r_hcnt,    w_hcnt_nxt;
    logic               r_dead,    w_dead_nxt;
    logic               r_done_ph, w_done_ph_nxt;
    logic               w_abort;
    logic               w_half_last;

    logic               r_pulse_p;
    logic               r_pulse_n;
    logic               r_tx_en;
    logic               r_tx_busy;
    logic               r_tx_done;

    // LUT write port; writes are accepted in every state
    always_ff @(posedge clk) begin
        if (bus.lut_we) begin
            r_lut[bus.lut_addr] <= bus.lut_din;
        end else begin
            r_lut[bus.lut_addr] <= r_lut[bus.lut_addr];
        end
    end

    // Next-state and counter logic
    always_comb begin
        w_state_nxt   = r_state;
        w_zone_nxt    = r_zone;
        w_half_nxt    = r_half;
        w_cyc_nxt     = r_cyc;
        w_dly_nxt     = r_dly;
        w_hcnt_nxt    = r_hcnt;
        w_dead_nxt    = r_dead;
        w_done_ph_nxt = r_done_ph;
        w_abort       = bus.tx_abort && (r_state != S_IDLE);
        w_half_last   = (r_hcnt == (r_half - HALF_WD'(1)));

        case (r_state)
            S_IDLE: begin
                // r_tx_busy still covers the cycle right after DONE, so a
                // trigger there is dropped rather than queued
                if (bus.tx_trig && !r_tx_busy) begin
                    w_state_nxt = S_LOAD;
                    w_zone_nxt  = bus.zone_sel;
                    w_half_nxt  = (bus.half_period == HALF_WD'(0)) ?
                                  HALF_WD'(1) : bus.half_period;
                    w_cyc_nxt   = bus.num_cycles;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_LOAD: begin
                // Registering the LUT word into the down-counter is the
                // synchronous read; a same-edge write to this zone is not seen
                w_dly_nxt   = r_lut[r_zone];
                w_state_nxt = S_DELAY;
            end
            S_DELAY: begin
                if (r_dly == DLY_WD'(0)) begin
                    w_hcnt_nxt  = HALF_WD'(0);
                    w_dead_nxt  = 1'b0;
                    w_state_nxt = (r_cyc == CYC_WD'(0)) ? S_DONE : S_PULSE_P;
                end else begin
                    w_dly_nxt = r_dly - DLY_WD'(1);
                end
            end
            S_PULSE_P: begin
                if (r_dead) begin
                    w_dead_nxt = 1'b0;
                end else if (w_half_last) begin
                    w_hcnt_nxt  = HALF_WD'(0);
                    w_dead_nxt  = DEAD_EN;
                    w_state_nxt = S_PULSE_N;
                end else begin
                    w_hcnt_nxt = r_hcnt + HALF_WD'(1);
                end
            end
            S_PULSE_N: begin
                if (r_dead) begin
                    w_dead_nxt = 1'b0;
                end else if (w_half_last) begin
                    w_hcnt_nxt = HALF_WD'(0);
                    w_cyc_nxt  = r_cyc - CYC_WD'(1);
                    if (r_cyc == CYC_WD'(1)) begin
                        w_dead_nxt  = 1'b0;
                        w_state_nxt = S_DONE;
                    end else begin
                        w_dead_nxt  = DEAD_EN;
                        w_state_nxt = S_PULSE_P;
                    end
                end else begin
                    w_hcnt_nxt = r_hcnt + HALF_WD'(1);
                end
            end
            S_DONE: begin
                // First DONE cycle lets the last registered pulse drain low;
                // the second one raises tx_done and returns to IDLE
                if (r_done_ph) begin
                    w_done_ph_nxt = 1'b0;
                    w_state_nxt   = S_IDLE;
                end else begin
                    w_done_ph_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Abort overrides any transition decided above
        if (w_abort) begin
            w_state_nxt   = S_IDLE;
            w_dead_nxt    = 1'b0;
            w_done_ph_nxt = 1'b0;
        end else begin
            w_state_nxt = w_state_nxt;
        end
    end

    // State and counter registers
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_state   <= S_IDLE;
            r_zone    <= ADDR_WD'(0);
            r_half    <= HALF_WD'(0);
            r_cyc     <= CYC_WD'(0);
            r_dly     <= DLY_WD'(0);
            r_hcnt    <= HALF_WD'(0);
            r_dead    <= 1'b0;
            r_done_ph <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_zone    <= w_zone_nxt;
            r_half    <= w_half_nxt;
            r_cyc     <= w_cyc_nxt;
            r_dly     <= w_dly_nxt;
            r_hcnt    <= w_hcnt_nxt;
            r_dead    <= w_dead_nxt;
            r_done_ph <= w_done_ph_nxt;
        end
    end

    // Output registers: decoded from the current state, so P and N are
    // mutually exclusive by construction; abort clears them on its edge
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_pulse_p <= 1'b0;
            r_pulse_n <= 1'b0;
            r_tx_en   <= 1'b0;
            r_tx_busy <= 1'b0;
            r_tx_done <= 1'b0;
        end else if (w_abort) begin
            r_pulse_p <= 1'b0;
            r_pulse_n <= 1'b0;
            r_tx_en   <= 1'b0;
            r_tx_busy <= 1'b0;
            r_tx_done <= 1'b0;
        end else begin
            r_pulse_p <= (r_state == S_PULSE_P) && !r_dead;
            r_pulse_n <= (r_state == S_PULSE_N) && !r_dead;
            r_tx_en   <= (r_state == S_PULSE_P) || (r_state == S_PULSE_N);
            r_tx_busy <= (r_state != S_IDLE);
            r_tx_done <= (r_state == S_DONE) && r_done_ph;
        end
    end

    assign bus.pulse_p = r_pulse_p;
    assign bus.pulse_n = r_pulse_n;
    assign bus.tx_en   = r_tx_en;
    assign bus.tx_busy = r_tx_busy;
    assign bus.tx_done = r_tx_done;

endmodule

// File: tb/tb_tx_pulse_ch.sv
// -----------------------------------------------------------------------------
// tb_tx_pulse_ch
// Self-checking bench for tx_pulse_ch: a table of transmit vectors, hand
// sequences for re-trigger/LUT-write during delay, abort and async reset, and
// randomized transmits, all compared cycle by cycle against a waveform model
// computed from the timing rules (start 3+D, train length, tx_done 4+D+L).
// -----------------------------------------------------------------------------
module tb_tx_pulse_ch;
    localparam int DLY_WD  = 12;
    localparam int ADDR_WD = 7;
    localparam int HALF_WD = 4;
    localparam int CYC_WD  = 4;
`ifdef TX_DEAD_TIME_EN
    localparam bit DEAD = 1'b1;
`else
    localparam bit DEAD = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    tx_pulse_ch_if #(.DLY_WD(DLY_WD), .ADDR_WD(ADDR_WD),
                     .HALF_WD(HALF_WD), .CYC_WD(CYC_WD)) bus ();

    tx_pulse_ch #(.DLY_WD(DLY_WD), .ADDR_WD(ADDR_WD),
                  .HALF_WD(HALF_WD), .CYC_WD(CYC_WD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int addr;
        int dly;
        int half;
        int ncyc;
        int exp_first;   // edge where pulse_p first rises (0 = never)
        int exp_en;      // number of cycles with tx_en high
        int exp_done;    // edge where tx_done rises
    } vec_t;

    // Pulse-train length in cycles
    function automatic int train_len(input int h, input int n);
        int he;
        int l;
        he = (h == 0) ? 1 : h;
        l  = 2 * he * n;
        if (DEAD && n > 0) l = l + 2 * n - 1;
        return l;
    endfunction

    // Expected {pulse_p, pulse_n, tx_en, tx_busy, tx_done} after edge k
    function automatic logic [4:0] model(input int k, input int d, input int h, input int n);
        int   he;
        int   l;
        int   s;
        int   o;
        logic p;
        logic q;
        logic en;
        logic busy;
        logic done;
        he   = (h == 0) ? 1 : h;
        l    = train_len(h, n);
        s    = 3 + d;
        p    = 1'b0;
        q    = 1'b0;
        en   = 1'b0;
        busy = (k >= 1) && (k <= 4 + d + l);
        done = (k == 4 + d + l);
        if (k >= s && k < s + l) begin
            en = 1'b1;
            o  = k - s;
            if (DEAD) begin
                if ((o % (he + 1)) != he) begin
                    p = ((o / (he + 1)) % 2) == 0;
                    q = !p;
                end
            end else begin
                p = ((o / he) % 2) == 0;
                q = !p;
            end
        end
        return {p, q, en, busy, done};
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int outs();
        return int'({bus.pulse_p, bus.pulse_n, bus.tx_en, bus.tx_busy, bus.tx_done});
    endfunction

    task automatic write_lut(input int a, input int d);
        bus.lut_we   = 1'b1;
        bus.lut_addr = ADDR_WD'(a);
        bus.lut_din  = DLY_WD'(d);
        @(negedge clk);
        bus.lut_we   = 1'b0;
    endtask

    // One transmit: trigger on the next edge (edge 0), then sample after
    // every edge k and compare to the model. poke_k re-triggers and writes
    // LUT[zone]=100 for one cycle; abort_k raises tx_abort for one cycle;
    // rst_k asserts reset between edges and returns.
    task automatic run_tx(input int zone, input int d, input int h, input int n,
                          input int poke_k, input int abort_k, input int rst_k,
                          output int first_p, output int en_cnt, output int done_k);
        int limit;
        int exp;
        first_p = 0;
        en_cnt  = 0;
        done_k  = 0;
        limit   = 5 + d + train_len(h, n);
        if (abort_k > 0) limit = abort_k + 1;
        bus.zone_sel    = ADDR_WD'(zone);
        bus.half_period = HALF_WD'(h);
        bus.num_cycles  = CYC_WD'(n);
        bus.tx_trig     = 1'b1;
        @(negedge clk);
        bus.tx_trig     = 1'b0;
        bus.half_period = HALF_WD'($urandom);
        bus.num_cycles  = CYC_WD'($urandom);
        bus.zone_sel    = ADDR_WD'($urandom);
        for (int k = 1; k <= limit; k++) begin
            @(negedge clk);
            exp = (abort_k > 0 && k > abort_k) ? 0 : int'(model(k, d, h, n));
            check($sformatf("wave z=%0d d=%0d h=%0d n=%0d k=%0d", zone, d, h, n, k), outs(), exp);
            if (bus.pulse_p && first_p == 0) first_p = k;
            if (bus.tx_en) en_cnt++;
            if (bus.tx_done) done_k = k;
            if (k == rst_k) begin
                #1 rst_n = 1'b1;
                #1;
                check("async reset outputs", outs(), 0);
                return;
            end
            bus.tx_trig  = (k == poke_k);
            bus.lut_we   = (k == poke_k);
            bus.lut_addr = ADDR_WD'(zone);
            bus.lut_din  = DLY_WD'(100);
            bus.tx_abort = (k == abort_k);
        end
        bus.tx_trig  = 1'b0;
        bus.lut_we   = 1'b0;
        bus.tx_abort = 1'b0;
    endtask

    initial begin
        vec_t tbl[6];
        int   fp;
        int   ec;
        int   dk;
        int   ab_k;
        int   rz;
        int   rd;
        int   rh;
        int   rn;

        total = 0;
        bad   = 0;
        rst_n = 1'b1;
        bus.lut_we      = 1'b0;
        bus.lut_addr    = '0;
        bus.lut_din     = '0;
        bus.zone_sel    = '0;
        bus.half_period = '0;
        bus.num_cycles  = '0;
        bus.tx_trig     = 1'b0;
        bus.tx_abort    = 1'b0;

        repeat (3) @(negedge clk);
        check("reset outputs", outs(), 0);
        rst_n = 1'b0;
        @(negedge clk);
        check("idle after reset", outs(), 0);

        tbl[0] = '{5,    5,  2, 3, 8,    DEAD ? 17 : 12, DEAD ? 26 : 21};
        tbl[1] = '{0,    0,  0, 1, 3,    DEAD ? 3 : 2,   DEAD ? 7 : 6};
        tbl[2] = '{9,    4,  3, 0, 0,    0,              8};
        tbl[3] = '{127,  1,  1, 2, 4,    DEAD ? 7 : 4,   DEAD ? 12 : 9};
        tbl[4] = '{64,   3, 15, 1, 6,    DEAD ? 31 : 30, DEAD ? 38 : 37};
        tbl[5] = '{3, 4095,  1, 1, 4098, DEAD ? 3 : 2,   DEAD ? 4102 : 4101};

        foreach (tbl[i]) begin
            write_lut(tbl[i].addr, tbl[i].dly);
            run_tx(tbl[i].addr, tbl[i].dly, tbl[i].half, tbl[i].ncyc, 0, 0, 0, fp, ec, dk);
            check($sformatf("vec%0d first pulse_p edge", i), fp, tbl[i].exp_first);
            check($sformatf("vec%0d tx_en cycles", i), ec, tbl[i].exp_en);
            check($sformatf("vec%0d tx_done edge", i), dk, tbl[i].exp_done);
        end

        // Re-trigger and LUT[5]=100 during DELAY: timing unchanged, next uses 100
        run_tx(5, 5, 2, 3, 3, 0, 0, fp, ec, dk);
        check("retrig first pulse_p edge", fp, 8);
        run_tx(5, 100, 2, 3, 0, 0, 0, fp, ec, dk);
        check("new delay first pulse_p edge", fp, 103);

        // Abort in the second PULSE_N phase, then retrigger one cycle later
        write_lut(7, 2);
        ab_k = DEAD ? 14 : 11;
        run_tx(7, 2, 2, 3, 0, ab_k, 0, fp, ec, dk);
        check("abort no tx_done", dk, 0);
        run_tx(7, 2, 1, 1, 0, 0, 0, fp, ec, dk);
        check("post-abort first pulse_p edge", fp, 5);

        // Async reset mid-PULSE_P, LUT retained afterwards
        run_tx(7, 2, 3, 2, 0, 0, 6, fp, ec, dk);
        check("pulse_p before reset", fp, 5);
        repeat (2) @(negedge clk);
        check("outputs held in reset", outs(), 0);
        rst_n = 1'b0;
        @(negedge clk);
        run_tx(5, 100, 1, 1, 0, 0, 0, fp, ec, dk);
        check("lut kept first pulse_p edge", fp, 103);

        // Randomized transmits
        for (int r = 0; r < 12; r++) begin
            rz = $urandom_range(10, 126);
            rd = $urandom_range(0, 40);
            rh = $urandom_range(0, 5);
            rn = $urandom_range(0, 4);
            write_lut(rz, rd);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_tx(rz, rd, rh, rn, 0, 0, 0, fp, ec, dk);
            check($sformatf("rand%0d tx_en cycles", r), ec, train_len(rh, rn) - (DEAD && rn > 0 ? 0 : 0));
            check($sformatf("rand%0d tx_done edge", r), dk, 4 + rd + train_len(rh, rn));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
